// File: rtl/alu_exec_unit_if.sv
// Request/response bundle for alu_exec_unit: operands and opcode in,
// handshake and registered results out.
interface alu_exec_unit_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               start;
  logic [2:0]         ALUop;
  logic [5:0]         function_code;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [SHAMT_W-1:0] shamt;
  logic               ready;
  logic               done;
  logic [WIDTH-1:0]   result;
  logic [WIDTH-1:0]   result_hi;
  logic               zero;
  logic               illegal;

  modport master (
    output start, ALUop, function_code, a, b, shamt,
    input  ready, done, result, result_hi, zero, illegal
  );

  modport slave (
    input  start, ALUop, function_code, a, b, shamt,
    output ready, done, result, result_hi, zero, illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: decodes ALUop/funct, single-cycle logic/arith/shift ops and
// a radix-2 iterative unsigned multiply behind a start/ready/done handshake.
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  alu_exec_unit_if.slave   io
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_SLT = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_ILL = 4'd9;

  localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);

  logic [WIDTH-1:0]   a_in, b_in;
  logic [SHAMT_W-1:0] sh_in;
  logic [3:0]         op;
  logic [WIDTH-1:0]   alu_res;

  assign a_in  = io.a;
  assign b_in  = io.b;
  assign sh_in = io.shamt;

  // Opcode decode
  always_comb begin
    op = OP_ILL;
    case (io.ALUop)
      3'b000: op = OP_AND;
      3'b001: op = OP_OR;
      3'b100: op = OP_SLT;
      3'b101: op = OP_ADD;
      3'b110: op = OP_SUB;
      3'b111: begin
        case (io.function_code)
          6'b000010: op = OP_ADD;
          6'b000011: op = OP_SUB;
          6'b000100: op = OP_AND;
          6'b000101: op = OP_OR;
          6'b000111: op = OP_SLT;
          6'b001000: op = OP_SLL;
          6'b001001: op = OP_SRL;
          6'b001010: op = OP_SRA;
          6'b011000: op = OP_MUL;
          default:   op = OP_ILL;
        endcase
      end
      default: op = OP_ILL;
    endcase
  end

  // Single-cycle datapath; illegal (and MUL, never taken here) yield 0
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD: alu_res = a_in + b_in;
      OP_SUB: alu_res = a_in - b_in;
      OP_AND: alu_res = a_in & b_in;
      OP_OR:  alu_res = a_in | b_in;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_in) < $signed(b_in))};
      OP_SLL: alu_res = b_in << sh_in;
      OP_SRL: alu_res = b_in >> sh_in;
      OP_SRA: alu_res = $signed(b_in) >>> sh_in;
      default: alu_res = '0;
    endcase
  end

  logic [0:0]         state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  logic               zero_q, zero_d;
  logic               illegal_q, illegal_d;
  logic               done_q, done_d;

  // Product register holds {accumulator, remaining multiplier bits}; each
  // step conditionally adds the multiplicand to the top and shifts right.
  logic [WIDTH:0]     step_sum;
  logic [2*WIDTH-1:0] prod_step;

  always_comb begin
    step_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                {1'b0, (prod_q[0] ? mcand_q : {WIDTH{1'b0}})};
    prod_step = {step_sum, prod_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    prod_d      = prod_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (io.start) begin
          if (op == OP_MUL) begin
            state_d = S_MUL;
            mcand_d = a_in;
            prod_d  = {{WIDTH{1'b0}}, b_in};
            cnt_d   = '0;
          end else begin
            done_d      = 1'b1;
            result_d    = alu_res;
            result_hi_d = '0;
            zero_d      = (alu_res == '0);
            illegal_d   = (op == OP_ILL);
          end
        end
      end
      default: begin
        prod_d = prod_step;
        cnt_d  = cnt_q + SHAMT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d     = S_IDLE;
          cnt_d       = '0;
          done_d      = 1'b1;
          result_d    = prod_step[WIDTH-1:0];
          result_hi_d = prod_step[2*WIDTH-1:WIDTH];
          zero_d      = (prod_step[WIDTH-1:0] == '0);
          illegal_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      prod_q      <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b1;
      illegal_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      prod_q      <= prod_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      done_q      <= done_d;
    end
  end

  assign io.ready     = (state_q == S_IDLE);
  assign io.done      = done_q;
  assign io.result    = result_q;
  assign io.result_hi = result_hi_q;
  assign io.zero      = zero_q;
  assign io.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit (WIDTH=32).
module tb_alu_exec_unit;
  localparam int W  = 32;
  localparam int SW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_exec_unit_if #(.WIDTH(W), .SHAMT_W(SW)) bus ();

  alu_exec_unit #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk     (clk),
    .reset_n (rst_n),
    .io      (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [5:0] fn,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic [SW-1:0] sh);
    bus.start = 1'b1; bus.ALUop = op; bus.function_code = fn;
    bus.a = a; bus.b = b; bus.shamt = sh;
  endtask

  // Issue one op at a negedge; on return we sit at the negedge after the sample edge.
  task automatic run1(input logic [2:0] op, input logic [5:0] fn,
                      input logic [W-1:0] a, input logic [W-1:0] b, input logic [SW-1:0] sh);
    drive(op, fn, a, b, sh);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic check_res(input string tag, input logic [W-1:0] r, input logic [W-1:0] rhi,
                           input logic z, input logic ill);
    chk({tag, ".done"}, 64'(bus.done), 64'd1);
    chk({tag, ".res"}, 64'(bus.result), 64'(r));
    chk({tag, ".hi"}, 64'(bus.result_hi), 64'(rhi));
    chk({tag, ".zero"}, 64'(bus.zero), 64'(z));
    chk({tag, ".ill"}, 64'(bus.illegal), 64'(ill));
  endtask

  // MULTU with busy-cycle start noise (ADD 1+1) that must be ignored.
  task automatic run_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] rlo, input logic [W-1:0] rhi);
    int busy_bad;
    busy_bad = 0;
    drive(3'b111, 6'b011000, a, b, '0);
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      if (bus.ready !== 1'b0 || bus.done !== 1'b0) busy_bad++;
      drive(3'b101, 6'b0, 32'd1, 32'd1, '0);
    end
    chk({tag, ".busy"}, 64'(busy_bad), 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    check_res(tag, rlo, rhi, (rlo == '0), 1'b0);
    chk({tag, ".rdy"}, 64'(bus.ready), 64'd1);
    @(negedge clk);
    chk({tag, ".done_lo"}, 64'(bus.done), 64'd0);
    chk({tag, ".hold"}, 64'(bus.result), 64'(rlo));
  endtask

  initial begin
    int dones;
    bus.start = 1'b0; bus.ALUop = '0; bus.function_code = '0;
    bus.a = '0; bus.b = '0; bus.shamt = '0;
    #12;
    chk("rst.ready", 64'(bus.ready), 64'd1);
    chk("rst.done", 64'(bus.done), 64'd0);
    chk("rst.res", 64'(bus.result), 64'd0);
    chk("rst.hi", 64'(bus.result_hi), 64'd0);
    chk("rst.zero", 64'(bus.zero), 64'd1);
    chk("rst.ill", 64'(bus.illegal), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    run1(3'b111, 6'b000011, 32'd5, 32'd7, '0);
    check_res("sub57", 32'hFFFF_FFFE, '0, 1'b0, 1'b0);
    chk("sub57.rdy", 64'(bus.ready), 64'd1);
    @(negedge clk);
    chk("sub57.pulse", 64'(bus.done), 64'd0);
    chk("sub57.hold", 64'(bus.result), 64'hFFFF_FFFE);
    run1(3'b111, 6'b000011, 32'd9, 32'd9, '0);
    check_res("sub99", '0, '0, 1'b1, 1'b0);
    run1(3'b100, 6'b0, 32'hFFFF_FFFF, 32'd1, '0);
    check_res("slti", 32'd1, '0, 1'b0, 1'b0);
    run1(3'b111, 6'b000111, 32'd1, 32'hFFFF_FFFF, '0);
    check_res("slt", '0, '0, 1'b1, 1'b0);
    run1(3'b000, 6'b0, 32'h0000_F0F0, 32'h0000_FF00, '0);
    check_res("andi", 32'h0000_F000, '0, 1'b0, 1'b0);
    run1(3'b001, 6'b0, 32'h0000_F0F0, 32'h0000_0F0F, '0);
    check_res("ori", 32'h0000_FFFF, '0, 1'b0, 1'b0);
    run1(3'b111, 6'b001001, 32'd0, 32'h8000_0000, 5'd4);
    check_res("srl", 32'h0800_0000, '0, 1'b0, 1'b0);
    run1(3'b110, 6'b0, 32'd0, 32'd1, '0);
    check_res("subi", 32'hFFFF_FFFF, '0, 1'b0, 1'b0);
    run1(3'b111, 6'b000010, 32'hFFFF_FFFF, 32'd1, '0);
    check_res("addwrap", '0, '0, 1'b1, 1'b0);

    // back-to-back single-cycle ops
    drive(3'b111, 6'b000010, 32'd3, 32'd4, '0);
    @(negedge clk);
    check_res("b2b.add", 32'd7, '0, 1'b0, 1'b0);
    drive(3'b111, 6'b001010, 32'd0, 32'h8000_0000, 5'd4);
    @(negedge clk);
    check_res("b2b.sra", 32'hF800_0000, '0, 1'b0, 1'b0);
    drive(3'b111, 6'b001000, 32'd0, 32'd1, 5'd31);
    @(negedge clk);
    bus.start = 1'b0;
    check_res("b2b.sll", 32'h8000_0000, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b.end", 64'(bus.done), 64'd0);

    run_mul("mulmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE);

    run1(3'b111, 6'b111111, 32'd3, 32'd4, '0);
    check_res("ill.fn", '0, '0, 1'b1, 1'b1);
    run1(3'b010, 6'b000010, 32'd3, 32'd4, '0);
    check_res("ill.op", '0, '0, 1'b1, 1'b1);
    run1(3'b011, 6'b000010, 32'd3, 32'd4, '0);
    check_res("ill.op3", '0, '0, 1'b1, 1'b1);
    run1(3'b101, 6'b0, 32'd1, 32'd1, '0);
    check_res("ill.clr", 32'd2, '0, 1'b0, 1'b0);

    run_mul("mul67", 32'd6, 32'd7, 32'd42, '0);
    run_mul("mul0", 32'd0, 32'h1234_5678, '0, '0);
    run1(3'b101, 6'b0, 32'd1, 32'd1, '0);

    // reset mid-multiply: no done afterwards
    drive(3'b111, 6'b011000, 32'd3, 32'd5, '0);
    repeat (5) @(negedge clk);
    bus.start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rstmul.ready", 64'(bus.ready), 64'd1);
    chk("rstmul.done", 64'(bus.done), 64'd0);
    chk("rstmul.res", 64'(bus.result), 64'd0);
    chk("rstmul.zero", 64'(bus.zero), 64'd1);
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    chk("rstmul.nodone", 64'(dones), 64'd0);
    chk("rstmul.idle", 64'(bus.ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
